ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage of the RISC-V core. Holds the program counter, issues one-outstanding-request reads to instruction memory over a req/gnt/rvalid handshake, and buffers each returned word in a single-entry output register. Decode pulls instructions through a valid/ready handshake. Redirects from execute (branch/jump) flush the buffer and discard any in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- XLEN, 32, address/data width
- clk  in  1  rising-edge clock
- rstn  in  1  synchronous, active-low reset
- redirect_valid  in  1  load redirect_pc as next fetch PC, flush
- redirect_pc  in  XLEN  redirect target; bits [1:0] forced to 0 internally
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address, word aligned
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  XLEN  instruction word
- inst_valid  out  1  output buffer full
- inst_ready  in  1  decode accepts buffer this cycle
- inst_data  out  XLEN  buffered instruction
- inst_pc  out  XLEN  PC of inst_data

## Operation
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, state=IDLE, drop=0, pc=RESET_PC.
- States: IDLE -> REQ (unconditionally, one cycle after reset release); REQ -> WAIT on imem_gnt; WAIT -> REQ on imem_rvalid when buffer will be free (empty, or inst_valid&inst_ready this cycle), else WAIT -> IDLE; IDLE -> REQ when buffer will be free.
- REQ: imem_req=1, imem_addr=req_addr; req_addr and imem_req held stable until imem_gnt (no retraction).
- On imem_rvalid in WAIT with drop=0: inst_data<=imem_rdata, inst_pc<=req_addr, inst_valid<=1, pc<=req_addr+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0). req_addr for next REQ = new pc.
- Buffer drains when inst_valid&inst_ready; inst_valid<=0 unless refilled same cycle.
- Redirect (highest priority): pc<=redirect_pc&~3, inst_valid<=0. If state is REQ or WAIT, drop<=1: the outstanding request completes its handshake; its response is discarded, drop<=0, then REQ at new pc. Redirect in IDLE: next state REQ at new pc.
- Redirect coincident with rvalid: response discarded; redirect coincident with inst_ready: handshake counts, buffer still flushed.
- Repeated redirects while drop=1: latest pc wins, only one response dropped.
- rvalid outside WAIT is ignored.

## Timing
- First imem_req: first cycle after IDLE (2nd cycle after rstn rises).
- gnt in cycle N, rvalid in N+k (k>=1): inst_valid high from N+k+1; next imem_req in N+k+1 if buffer free.
- Peak throughput: one instruction per 2 cycles with single-cycle memory.
- Redirect in cycle R with no request outstanding: imem_req with new address in R+1.
- Reset mid-transaction: all state returns to reset values next edge; late rvalid ignored (state IDLE).

## Configuration
- IFETCH_STATS_EN defined: adds output fetch_count (32 bits, reset 0) incremented on every inst_valid&inst_ready, wraps at 2^32; dropped responses not counted.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- ifetch_pkg: state enum (IDLE, REQ, WAIT), RESET_PC default, PC_INC = 4.
- inst_data held in an instance of the existing register block (wr = accepted rvalid, reset via rstn); inst_pc and control in ifetch.

## Test plan
- Reset release, memory grants immediately, rvalid next cycle, rdata 32'h0000_0013 -> imem_addr 0 then 4; inst_valid with inst_pc 0, inst_data 32'h0000_0013.
- inst_ready held 0 after first fill -> no second imem_req until inst_ready=1; then request at address 4.
- Redirect to 32'h0000_0103 while in WAIT, stale rdata 32'hDEADBEEF -> not presented; next imem_addr 32'h0000_0100.
- Redirect during REQ with gnt delayed 3 cycles -> old address held stable, response dropped, then REQ at target.
- Redirect to 32'hFFFF_FFFC, fetch two words -> inst_pc FFFF_FFFC then 0.
- rstn low while in WAIT, rvalid arrives after -> inst_valid stays 0, first request at RESET_PC; with IFETCH_STATS_EN, fetch_count resets to 0 and counts 3 after 3 accepted instructions.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ifetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned PC_INC       = 4;

endpackage

// File: rtl/ifetch_reg.sv
// Generic enabled register with synchronous active-low reset to zero.
module ifetch_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         wr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rstn)
            r_q <= '0;
        else if (wr)
            r_q <= d;
    end

    assign q = r_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC, single-outstanding imem handshake, one-entry output buffer.
// Optional IFETCH_STATS_EN adds a fetch_count output of accepted instructions.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
`ifdef IFETCH_STATS_EN
    output logic [31:0]     fetch_count,
`endif
    input  logic            clk,
    input  logic            rstn,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    ifetch_state_e   r_state, w_next;
    logic            r_drop;
    logic            r_inst_valid;
    logic [XLEN-1:0] r_pc, r_req_addr, r_inst_pc;
    logic [XLEN-1:0] w_pc_next;
    logic            w_buf_free, w_rsp, w_accept;

    assign w_buf_free = !r_inst_valid || inst_ready;
    assign w_rsp      = (r_state == WAIT) && imem_rvalid;
    // A response coinciding with a redirect belongs to the old stream.
    assign w_accept   = w_rsp && !r_drop && !redirect_valid;

    always_comb begin
        w_pc_next = r_pc;
        if (redirect_valid)
            w_pc_next = redirect_pc & ~XLEN'(3);
        else if (w_accept)
            w_pc_next = r_req_addr + XLEN'(PC_INC);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_buf_free || redirect_valid) w_next = REQ;
            REQ:     if (imem_gnt) w_next = WAIT;
            WAIT:    if (imem_rvalid)
                         w_next = (r_drop || redirect_valid || w_buf_free) ? REQ : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_drop       <= 1'b0;
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_inst_pc    <= '0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            // Address is latched on entry to REQ and held until granted.
            if (w_next == REQ && r_state != REQ)
                r_req_addr <= w_pc_next;
            if (w_rsp)
                r_drop <= 1'b0;
            else if (redirect_valid && r_state != IDLE)
                r_drop <= 1'b1;
            if (redirect_valid)
                r_inst_valid <= 1'b0;
            else if (w_accept)
                r_inst_valid <= 1'b1;
            else if (inst_ready)
                r_inst_valid <= 1'b0;
            if (w_accept)
                r_inst_pc <= r_req_addr;
        end
    end

    ifetch_reg #(.W(XLEN)) u_data_reg (
        .clk  (clk),
        .rstn (rstn),
        .wr   (w_accept),
        .d    (imem_rdata),
        .q    (inst_data)
    );

`ifdef IFETCH_STATS_EN
    logic [31:0] r_fetch_count;

    always_ff @(posedge clk) begin
        if (!rstn)
            r_fetch_count <= '0;
        else if (r_inst_valid && inst_ready)
            r_fetch_count <= r_fetch_count + 32'd1;
    end

    assign fetch_count = r_fetch_count;
`endif

    assign imem_req   = (r_state == REQ);
    assign imem_addr  = r_req_addr;
    assign inst_valid = r_inst_valid;
    assign inst_pc    = r_inst_pc;

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch: the bench acts as instruction memory and decode and
// tracks the expected fetch stream at transaction level.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rstn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef IFETCH_STATS_EN
    logic [31:0] fetch_count;
`endif

    ifetch dut (
`ifdef IFETCH_STATS_EN
        .fetch_count    (fetch_count),
`endif
        .clk            (clk),
        .rstn           (rstn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] STALE  = 32'hDEAD_BEEF;

    int n_chk = 0;
    int n_err = 0;

    // stimulus knobs
    int          k_gnt, k_ready, k_redir, k_dly;
    logic        f_redir, f_spur, f_late;
    logic [31:0] f_target;

    // reference model: expected fetch stream, output buffer, memory transaction
    logic        m_rst, m_req, m_vld, r_stale, o_act, o_stale;
    logic [31:0] m_pc, m_data, m_haddr, exp_pc, o_addr, m_cnt;
    int          o_cnt;
    logic [31:0] log_pc[$];
    logic [31:0] log_data[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h0000_0010;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rst = 1'b1; m_req = 1'b0; m_vld = 1'b0; r_stale = 1'b0;
        o_act = 1'b0; o_stale = 1'b0; o_cnt = 0;
        exp_pc = RST_PC; m_haddr = RST_PC; m_cnt = '0;
        m_pc = '0; m_data = '0; o_addr = '0;
    endtask

    // One clock: check outputs, drive inputs, advance the model, move to the next negedge.
    task automatic step();
        logic rd, gn, rv, rdy, free, acc, hold, nreq;
        logic [31:0] rdat, rpc;
        check("imem_req", 32'(imem_req), 32'(m_req));
        check("inst_valid", 32'(inst_valid), 32'(m_vld));
        if (m_vld) begin
            check("inst_pc", inst_pc, m_pc);
            check("inst_data", inst_data, m_data);
        end
        if (m_req || m_rst) check("imem_addr", imem_addr, m_haddr);
        if (m_rst) begin
            check("rst_inst_data", inst_data, 32'h0);
            check("rst_inst_pc", inst_pc, 32'h0);
        end
`ifdef IFETCH_STATS_EN
        check("fetch_count", fetch_count, m_cnt);
`endif
        rd = 1'b0; gn = 1'b0; rv = 1'b0; rdy = 1'b0;
        rdat = $urandom; rpc = $urandom;
        if (rstn) begin
            rd  = f_redir || ($urandom_range(99) < k_redir);
            if (f_redir) rpc = f_target;
            gn  = imem_req && ($urandom_range(99) < k_gnt);
            rdy = ($urandom_range(99) < k_ready);
        end
        if (o_act) begin
            if (o_cnt == 0) begin
                rv = 1'b1;
                rdat = o_stale ? STALE : mem(o_addr);
            end else o_cnt--;
        end else if (f_late || (f_spur && $urandom_range(3) == 0)) begin
            rv = 1'b1;
            rdat = STALE;
        end
        redirect_valid = rd; redirect_pc = rpc; imem_gnt = gn;
        imem_rvalid = rv; imem_rdata = rdat; inst_ready = rdy;
        if (inst_valid && rdy) begin
            log_pc.push_back(inst_pc);
            log_data.push_back(inst_data);
        end
        if (!rstn) model_reset();
        else begin
            free = !m_vld || rdy;
            acc  = rv && o_act;
            hold = m_req && !gn;
            if (hold)                 nreq = 1'b1;
            else if (acc)             nreq = o_stale || rd || free;
            else if (!m_req && !o_act) nreq = free || rd;
            else                      nreq = 1'b0;
            if (m_vld && rdy) m_cnt = m_cnt + 1;
            if (rd) m_vld = 1'b0;
            else if (acc && !o_stale) begin
                m_vld = 1'b1; m_pc = o_addr; m_data = mem(o_addr);
            end else if (rdy) m_vld = 1'b0;
            if (rd) exp_pc = rpc & ~32'h3;
            else if (acc && !o_stale) exp_pc = o_addr + 32'd4;
            if (m_req && gn) begin
                o_act = 1'b1; o_addr = m_haddr; o_stale = r_stale || rd;
                o_cnt = $urandom_range(k_dly - 1);
            end else if (acc) o_act = 1'b0;
            else if (o_act) o_stale = o_stale || rd;
            if (hold) r_stale = r_stale || rd;
            else if (nreq) begin
                r_stale = 1'b0; m_haddr = exp_pc;
            end
            m_req = nreq;
            m_rst = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_outstanding(input string tag);
        for (int i = 0; i < 60 && !o_act; i++) step();
        check(tag, 32'(o_act), 32'd1);
    endtask

    task automatic knobs(input int g, input int r, input int rd, input int d);
        k_gnt = g; k_ready = r; k_redir = rd; k_dly = d;
    endtask

    initial begin
        rstn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        f_redir = 1'b0; f_spur = 1'b0; f_late = 1'b0; f_target = '0;
        knobs(100, 100, 0, 1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        run(2);
        rstn = 1'b1;

        // single-cycle memory straight out of reset
        run(8);
        check("first_n", 32'(log_pc.size() >= 2), 32'd1);
        if (log_pc.size() >= 2) begin
            check("first_pc", log_pc[0], 32'h0);
            check("first_data", log_data[0], 32'h0000_0013);
            check("second_pc", log_pc[1], 32'h4);
        end

        // decode backpressure, then release
        knobs(100, 0, 0, 1);
        run(10);
        check("stall_req", 32'(imem_req), 32'd0);
        check("stall_vld", 32'(inst_valid), 32'd1);
        knobs(100, 100, 0, 1);
        run(6);

        // redirect while a response is outstanding
        knobs(100, 100, 0, 3);
        wait_outstanding("wait_for_wait");
        f_redir = 1'b1; f_target = 32'h0000_0103;
        step();
        f_redir = 1'b0;
        for (int i = 0; i < 20 && !(m_req && m_haddr == 32'h100); i++) step();
        check("redir_addr", imem_addr, 32'h0000_0100);
        run(6);

        // redirect during REQ with a slow grant
        knobs(0, 100, 0, 1);
        for (int i = 0; i < 20 && !imem_req; i++) step();
        check("slow_req", 32'(imem_req), 32'd1);
        f_redir = 1'b1; f_target = 32'h0000_0200;
        step();
        f_redir = 1'b0;
        run(2);
        knobs(100, 100, 0, 1);
        run(8);

        // wrap of the PC at the top of the address space
        f_redir = 1'b1; f_target = 32'hFFFF_FFFC;
        step();
        f_redir = 1'b0;
        log_pc.delete(); log_data.delete();
        run(12);
        check("wrap_n", 32'(log_pc.size() >= 2), 32'd1);
        if (log_pc.size() >= 2) begin
            check("wrap_pc0", log_pc[0], 32'hFFFF_FFFC);
            check("wrap_pc1", log_pc[1], 32'h0);
        end

        // reset while waiting, late response afterwards
        knobs(100, 100, 0, 4);
        wait_outstanding("rst_wait");
        rstn = 1'b0;
        run(3);
        rstn = 1'b1;
        f_late = 1'b1;
        step();
        f_late = 1'b0;
        check("late_vld", 32'(inst_valid), 32'd0);
        knobs(100, 100, 0, 1);
        log_pc.delete(); log_data.delete();
        for (int i = 0; i < 40 && log_pc.size() < 3; i++) step();
        check("rst_n3", 32'(log_pc.size()), 32'd3);
        if (log_pc.size() >= 1) check("rst_pc0", log_pc[0], RST_PC);
`ifdef IFETCH_STATS_EN
        check("fcnt3", fetch_count, 32'd3);
`endif

        // randomized mix
        f_spur = 1'b1;
        for (int b = 0; b < 30; b++) begin
            knobs($urandom_range(100, 30), $urandom_range(100, 20),
                  $urandom_range(10), $urandom_range(4, 1));
            run(100);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
